// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: issues one req/gnt/rvalid fetch at a time for the
// current pc, holds the word for execute, strobes pc_load and counts retirements.
module fetch_unit (
   input  logic        clk,
   input  logic        areset,
   input  logic [31:0] pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        pc_load,
   output logic        misaligned,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      EXEC,
      FAULT
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t state;
   state_t state_next;
   logic   pc_unaligned;

   assign pc_unaligned = (pc[1:0] != 2'b00);

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      imem_addr   = '0;
      instr_valid = 1'b0;
      pc_load     = 1'b0;
      unique case (state)
         IDLE: state_next = REQ;
         REQ: begin
            // A misaligned pc never reaches memory; the fault is latched instead.
            if (pc_unaligned) begin
               state_next = FAULT;
            end else begin
               imem_req  = 1'b1;
               imem_addr = pc;
               if (imem_gnt) state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) state_next = EXEC;
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (!stall) begin
               pc_load    = 1'b1;
               state_next = REQ;
            end
         end
         FAULT: state_next = FAULT;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         instr <= NOP;
      end else if (state == WAIT && imem_rvalid) begin
         instr <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         misaligned <= 1'b0;
      end else if (state == REQ && pc_unaligned) begin
         misaligned <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         retired <= '0;
      end else if (pc_load) begin
         retired <= retired + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change on the falling edge, outputs are
// checked 1 time unit later against hand-computed values.
module tb_fetch_unit;

   logic        clk;
   logic        areset;
   logic [31:0] pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        pc_load;
   logic        misaligned;
   logic [31:0] retired;

   int unsigned n_cmp;
   int unsigned n_bad;
   int unsigned loads;

   fetch_unit dut (
      .clk         (clk),
      .areset      (areset),
      .pc          (pc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc_load     (pc_load),
      .misaligned  (misaligned),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " imem_req"},    {31'd0, imem_req},    32'd0);
      check({tag, " imem_addr"},   imem_addr,            32'd0);
      check({tag, " instr"},       instr,                32'h0000_0013);
      check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, " pc_load"},     {31'd0, pc_load},     32'd0);
      check({tag, " misaligned"},  {31'd0, misaligned},  32'd0);
      check({tag, " retired"},     retired,              32'd0);
   endtask

   // Per-cycle table for the latency test: REQ x3, WAIT x3, EXEC x1.
   logic lat_gnt   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic lat_rv    [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic lat_req   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic lat_load  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      areset      = 1'b0;
      pc          = 32'h0;
      stall       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;

      // Reset, then fetch
      @(negedge clk);
      @(negedge clk);
      #1 check_reset_values("reset");
      areset = 1'b1;
      #1 check("idle no req", {31'd0, imem_req}, 32'd0);
      next_cycle();                                   // cycle 1: REQ
      imem_gnt = 1'b1;
      #1 check("c1 imem_req", {31'd0, imem_req}, 32'd1);
      check("c1 imem_addr", imem_addr, 32'h0);
      next_cycle();                                   // cycle 2: WAIT
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      #1 check("c2 imem_req", {31'd0, imem_req}, 32'd0);
      check("c2 instr_valid", {31'd0, instr_valid}, 32'd0);
      next_cycle();                                   // cycle 3: EXEC
      imem_rvalid = 1'b0;
      #1 check("c3 instr", instr, 32'h0050_0093);
      check("c3 instr_valid", {31'd0, instr_valid}, 32'd1);
      check("c3 pc_load", {31'd0, pc_load}, 32'd1);
      next_cycle();
      pc = 32'h4;
      #1 check("retired after 1", retired, 32'd1);
      check("new pc on addr", imem_addr, 32'h4);

      // Grant and response latency
      loads = 0;
      for (int i = 0; i < 7; i++) begin
         imem_gnt    = lat_gnt[i];
         imem_rvalid = lat_rv[i];
         imem_rdata  = lat_rv[i] ? 32'h0010_0113 : 32'hBAD0_BAD0;
         #1 check($sformatf("lat imem_req c%0d", i), {31'd0, imem_req}, {31'd0, lat_req[i]});
         if (lat_req[i]) check($sformatf("lat imem_addr c%0d", i), imem_addr, 32'h4);
         check($sformatf("lat pc_load c%0d", i), {31'd0, pc_load}, {31'd0, lat_load[i]});
         if (pc_load) loads++;
         next_cycle();
      end
      check("lat pc_load count", loads, 32'd1);
      check("lat instr", instr, 32'h0010_0113);
      pc = 32'h8;
      #1 check("retired after 2", retired, 32'd2);

      // Stall hold, with spurious gnt/rvalid that must be ignored
      imem_gnt = 1'b1;
      next_cycle();                                   // WAIT
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0020_81B3;
      next_cycle();                                   // EXEC
      stall       = 1'b1;
      imem_gnt    = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         #1 check($sformatf("stall pc_load c%0d", i), {31'd0, pc_load}, 32'd0);
         check($sformatf("stall instr_valid c%0d", i), {31'd0, instr_valid}, 32'd1);
         check($sformatf("stall instr c%0d", i), instr, 32'h0020_81B3);
         check($sformatf("stall imem_req c%0d", i), {31'd0, imem_req}, 32'd0);
         next_cycle();
      end
      stall       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      #1 check("stall release pc_load", {31'd0, pc_load}, 32'd1);
      next_cycle();
      pc = 32'hC;
      #1 check("stall single pulse", {31'd0, pc_load}, 32'd0);
      check("retired after 3", retired, 32'd3);

      // Counter wrap
      imem_gnt = 1'b1;
      next_cycle();                                   // WAIT
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0013;
      next_cycle();                                   // EXEC, stalled
      imem_rvalid = 1'b0;
      stall       = 1'b1;
      force dut.retired = 32'hFFFF_FFFF;
      #1 release dut.retired;
      #1 check("wrap preset", retired, 32'hFFFF_FFFF);
      next_cycle();
      stall = 1'b0;
      #1 check("wrap pc_load", {31'd0, pc_load}, 32'd1);
      next_cycle();
      pc = 32'h10;
      #1 check("wrap retired", retired, 32'd0);

      // Reset mid-WAIT
      imem_gnt = 1'b1;
      next_cycle();                                   // WAIT
      imem_gnt = 1'b0;
      #2 areset = 1'b0;
      #1 check_reset_values("midwait");
      @(negedge clk);
      imem_rvalid = 1'b1;                             // stale response, must be ignored
      areset = 1'b1;
      #1 check("post-reset idle req", {31'd0, imem_req}, 32'd0);
      next_cycle();
      imem_rvalid = 1'b0;
      #1 check("post-reset req", {31'd0, imem_req}, 32'd1);
      check("post-reset addr", imem_addr, 32'h10);
      check("post-reset instr", instr, 32'h0000_0013);

      // Misaligned fetch
      areset = 1'b0;
      pc     = 32'h6;
      @(negedge clk);
      areset = 1'b1;
      next_cycle();                                   // REQ with bad pc
      imem_gnt = 1'b1;
      #1 check("mis req", {31'd0, imem_req}, 32'd0);
      check("mis not yet", {31'd0, misaligned}, 32'd0);
      next_cycle();
      #1 check("mis set", {31'd0, misaligned}, 32'd1);
      check("mis fault req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         pc          = 32'h0;
         imem_gnt    = i[0];
         imem_rvalid = 1'b1;
         stall       = 1'b0;
         next_cycle();
         #1 check($sformatf("mis sticky c%0d", i), {31'd0, misaligned}, 32'd1);
         check($sformatf("mis fault req c%0d", i), {31'd0, imem_req}, 32'd0);
         check($sformatf("mis fault load c%0d", i), {31'd0, pc_load}, 32'd0);
         check($sformatf("mis fault valid c%0d", i), {31'd0, instr_valid}, 32'd0);
      end
      areset = 1'b0;
      #1 check("mis cleared by reset", {31'd0, misaligned}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer that sits directly downstream of the PC register. It reads the current `pc`, issues a request/grant/valid transaction to instruction memory, and holds the returned word in an instruction register for decode. It generates the one-cycle `pc_load` strobe that advances the PC register once the instruction has executed. It also flags misaligned fetch addresses and counts retired instructions.

## Interface
- No parameters; all datapaths are 32 bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `areset` in 1: asynchronous, active-low reset.
- `pc` in 32: current program counter from the PC register.
- `stall` in 1: execute stage not done (e.g. data memory busy); holds the current instruction.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address, equal to `pc` while `imem_req`=1, else 0.
- `imem_gnt` in 1: memory accepted the request this cycle.
- `imem_rvalid` in 1: `imem_rdata` is valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: instruction register.
- `instr_valid` out 1: `instr` is valid and being executed.
- `pc_load` out 1: one-cycle strobe to the PC register's `load` input.
- `misaligned` out 1: sticky fetch-misalignment fault.
- `retired` out 32: count of `pc_load` pulses since reset.

## Operation
- FSM states: IDLE, REQ, WAIT, EXEC, FAULT.
- **IDLE**: entered on reset. Moves to REQ unconditionally on the next edge.
- **REQ**:
  - If `pc[1:0]`≠0: `imem_req`=0, set `misaligned`, and go to FAULT.
  - Otherwise `imem_req`=1. If `imem_gnt`=1, go to WAIT; otherwise stay in REQ.
  - `imem_rvalid` is ignored in REQ.
- **WAIT**: `imem_req`=0. If `imem_rvalid`=1, capture `imem_rdata` into `instr` and go to EXEC; otherwise stay. There is no timeout.
- **EXEC**: `instr_valid`=1.
  - If `stall`=0: `pc_load`=1 (combinational, this cycle only), `retired` increments, and the FSM goes to REQ.
  - If `stall`=1: stay in EXEC; `instr` and `instr_valid` hold and `pc_load`=0.
- **FAULT**: terminal until reset. All of `imem_req`, `pc_load` and `instr_valid` are 0, and `misaligned`=1.
- `pc_load` is asserted only in EXEC with `stall`=0. It is never asserted twice for the same fetched word.
- `imem_rvalid` or `imem_gnt` outside the state that consumes it is ignored.
- Only one request is outstanding at any time.
- `retired` wraps from 0xFFFFFFFF to 0 with no flag.
- `instr` changes only on capture in WAIT. It keeps its old value in REQ, but `instr_valid`=0 there.

## Timing
- Reset values:
  - State IDLE.
  - `instr`=0x00000013 (NOP).
  - `instr_valid`=0, `pc_load`=0, `imem_req`=0, `imem_addr`=0, `misaligned`=0, `retired`=0.
- Reset is asynchronous. Asserting it in any state, including mid-WAIT, returns to IDLE immediately, and in-flight responses are abandoned.
  - Instruction memory shares `areset` and must drop outstanding responses.
- The first `imem_req` is asserted 1 cycle after `areset` deasserts (IDLE→REQ).
- Minimum cycles per instruction is 3 (REQ, WAIT, EXEC), with `imem_gnt` in the REQ cycle and `imem_rvalid` in the first WAIT cycle.
  - Each extra cycle of grant latency, response latency or `stall` adds 1 cycle.
- `pc` updates at the edge that ends the `pc_load` cycle. The following REQ cycle presents the new `pc` on `imem_addr`.
- `imem_addr` must stay stable while `imem_req`=1 and `imem_gnt`=0. This holds because `pc` cannot change outside `pc_load`.
- `misaligned` is checked on the `pc` value present in REQ. The fault sets at the end of that REQ cycle and no request is issued for that address.

## Test plan
- **Reset, then fetch**:
  - Stimulus: release `areset` with `pc`=0, `imem_gnt`=1, `imem_rvalid`=1 one cycle after the grant, `imem_rdata`=0x00500093.
  - Required: `imem_req` high in cycle 1; `instr`=0x00500093 with `instr_valid`=1 in cycle 3; `pc_load` pulses in cycle 3; `retired`=1.
- **Grant and response latency**:
  - Stimulus: `imem_gnt` delayed 2 cycles, `imem_rvalid` delayed 3 cycles.
  - Required: `imem_addr` stable for all 3 REQ cycles; instruction period is 3+2+2=7 cycles with exactly one `pc_load`.
- **Stall hold**:
  - Stimulus: hold `stall`=1 for 4 cycles in EXEC.
  - Required: `instr` and `instr_valid` hold; `pc_load`=0 for those 4 cycles, then a single pulse the cycle `stall` drops.
- **Misaligned fetch**:
  - Stimulus: `pc`=0x00000006.
  - Required: no `imem_req`; `misaligned`=1 from the next cycle and stays 1 regardless of further inputs until reset.
- **Reset mid-WAIT**:
  - Stimulus: assert `areset` while in WAIT, then release it.
  - Required: all outputs return to reset values immediately; a fresh fetch of the current `pc` starts 1 cycle after release.
- **Counter wrap**:
  - Stimulus: force `retired` to 0xFFFFFFFF, then retire one instruction.
  - Required: `retired`=0.
